// File: rtl/stream_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : stream_pattern_gen
// Description : Multi-link AXI-Stream pattern source (counter, PRBS-31 or
//               fixed word) with backpressure, programmable burst length and
//               a live accepted-beat count. Each 32-bit link of TDATA carries
//               its own pattern instance.
//               Optional build macro STREAM_PATTERN_GEN_ERR_INJECT_EN adds a
//               single-beat bit-0 corruption on link 0 plus an inject counter.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_pattern_gen #(
    parameter int          TDATA_WIDTH = 32,
    parameter logic [30:0] PRBS_SEED   = 31'h7FFFFFFF
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [1:0]             mode,
    input  logic [31:0]            fixed_word,
    input  logic [31:0]            num_words,
`ifdef STREAM_PATTERN_GEN_ERR_INJECT_EN
    input  logic                   err_inject,
    output logic [31:0]            inject_count,
`endif
    output logic [TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                   M_AXIS_TVALID,
    input  logic                   M_AXIS_TREADY,
    output logic                   M_AXIS_TLAST,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            words_sent
);

    localparam int         NLINKS       = TDATA_WIDTH / 32;
    localparam logic [1:0] C_MODE_PRBS  = 2'd1;
    localparam logic [1:0] C_MODE_FIXED = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Per-link seed; an all-zero LFSR would lock up, so it is replaced by 1.
    function automatic logic [30:0] link_seed(input int idx);
        logic [30:0] s;
        s = PRBS_SEED ^ 31'(idx);
        if (s == 31'd0) begin
            s = 31'd1;
        end
        return s;
    endfunction

    // 32 steps of x^31 + x^28 + 1; returns {word[31:0], next_state[30:0]}.
    // The first bit produced is placed in word bit 31.
    function automatic logic [62:0] prbs_step32(input logic [30:0] st);
        logic [30:0] s;
        logic [31:0] w;
        logic        nb;
        s = st;
        w = '0;
        for (int b = 0; b < 32; b++) begin
            nb        = s[30] ^ s[27];
            w[31 - b] = nb;
            s         = {s[29:0], nb};
        end
        return {w, s};
    endfunction

    state_t                   state_q, state_d;
    logic [1:0]               mode_q, mode_d;
    logic [31:0]              fixed_q, fixed_d;
    logic [31:0]              num_q, num_d;
    logic [31:0]              counter_q, counter_d;
    logic [30:0]              lfsr_q [NLINKS];
    logic [30:0]              lfsr_d [NLINKS];
    logic [TDATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                     tlast_q, tlast_d;
    logic [31:0]              words_q, words_d;
    logic                     stop_pend_q, stop_pend_d;

    logic                     w_hs;
    logic                     w_inj;
    logic [1:0]               w_src_mode;
    logic [31:0]              w_src_fixed;
    logic [31:0]              w_src_cnt;
    logic [30:0]              w_src_lfsr [NLINKS];
    logic [30:0]              w_lfsr_adv [NLINKS];
    logic [TDATA_WIDTH-1:0]   w_word;

    assign w_hs = (state_q == S_RUN) && M_AXIS_TREADY;

    // Word to load next: beat 0 of a new run while idle, otherwise the beat
    // following the one currently presented.
    always_comb begin : p_source
        logic [62:0] step;
        w_src_mode  = mode_q;
        w_src_fixed = fixed_q;
        w_src_cnt   = counter_q + 32'd1;
        w_src_lfsr  = lfsr_q;
        if (state_q == S_IDLE) begin
            w_src_mode  = mode;
            w_src_fixed = fixed_word;
            w_src_cnt   = '0;
            for (int i = 0; i < NLINKS; i++) begin
                w_src_lfsr[i] = link_seed(i);
            end
        end
        w_word = '0;
        for (int i = 0; i < NLINKS; i++) begin
            step          = prbs_step32(w_src_lfsr[i]);
            w_lfsr_adv[i] = step[30:0];
            case (w_src_mode)
                C_MODE_PRBS:  w_word[32*i +: 32] = step[62:31];
                C_MODE_FIXED: w_word[32*i +: 32] = w_src_fixed;
                default:      w_word[32*i +: 32] = w_src_cnt + 32'(i);
            endcase
        end
    end

    // Next-state logic for the run controller and the presented beat.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        fixed_d     = fixed_q;
        num_d       = num_q;
        counter_d   = counter_q;
        lfsr_d      = lfsr_q;
        tdata_d     = tdata_q;
        tlast_d     = tlast_q;
        words_d     = words_q;
        stop_pend_d = stop_pend_q;
        case (state_q)
            S_IDLE: begin
                stop_pend_d = 1'b0;
                if (start) begin
                    mode_d    = mode;
                    fixed_d   = fixed_word;
                    num_d     = num_words;
                    counter_d = '0;
                    lfsr_d    = w_lfsr_adv;
                    tdata_d   = w_word;
                    tlast_d   = (num_words == 32'd1);
                    words_d   = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (w_hs) begin
                    words_d   = words_q + 32'd1;
                    counter_d = counter_q + 32'd1;
                    lfsr_d    = w_lfsr_adv;
                    tdata_d   = w_word;
                    // Next presented beat index is words_q+1; last is num-1.
                    tlast_d   = (num_q != 32'd0) && (words_q + 32'd2 == num_q);
                    // tlast_q marks the accepted beat as number num_words.
                    if (tlast_q || stop_pend_q) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            fixed_q     <= '0;
            num_q       <= '0;
            counter_q   <= '0;
            tdata_q     <= '0;
            tlast_q     <= 1'b0;
            words_q     <= '0;
            stop_pend_q <= 1'b0;
            for (int i = 0; i < NLINKS; i++) begin
                lfsr_q[i] <= link_seed(i);
            end
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            fixed_q     <= fixed_d;
            num_q       <= num_d;
            counter_q   <= counter_d;
            lfsr_q      <= lfsr_d;
            tdata_q     <= tdata_d;
            tlast_q     <= tlast_d;
            words_q     <= words_d;
            stop_pend_q <= stop_pend_d;
        end
    end

`ifdef STREAM_PATTERN_GEN_ERR_INJECT_EN
    logic        inj_pend_q;
    logic [31:0] inj_cnt_q;

    assign w_inj        = inj_pend_q && (state_q == S_RUN);
    assign inject_count = inj_cnt_q;

    // Arm a one-shot corruption; it is consumed by the next accepted beat.
    always_ff @(posedge clk) begin
        if (areset) begin
            inj_pend_q <= 1'b0;
            inj_cnt_q  <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            inj_pend_q <= 1'b0;
        end else if (w_hs && inj_pend_q) begin
            inj_pend_q <= 1'b0;
            inj_cnt_q  <= inj_cnt_q + 32'd1;
        end else if (err_inject) begin
            inj_pend_q <= 1'b1;
        end
    end
`else
    assign w_inj = 1'b0;
`endif

    assign M_AXIS_TDATA  = tdata_q ^ {{(TDATA_WIDTH-1){1'b0}}, w_inj};
    assign M_AXIS_TVALID = (state_q == S_RUN);
    assign M_AXIS_TLAST  = tlast_q && (state_q == S_RUN);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_FIN);
    assign words_sent    = words_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_pattern_gen
// Description : Self-checking bench for stream_pattern_gen (two 32-bit links).
//               Table of runs plus hand-written corner sequences, checked
//               against a bit-sequence reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_pattern_gen;

    localparam int          TW   = 64;
    localparam logic [30:0] SEED = 31'h7FFFFFFF;
    localparam int          NPX  = 33000;

    logic          clk = 1'b0;
    logic          areset, start, stop, tready, tvalid, tlast, busy, done;
    logic [1:0]    mode;
    logic [31:0]   fixed_word, num_words, words_sent;
    logic [TW-1:0] tdata;
`ifdef STREAM_PATTERN_GEN_ERR_INJECT_EN
    logic          err_inject;
    logic [31:0]   inject_count;
`endif

    int errors = 0;
    int checks = 0;

    // Reference PRBS bit streams: x[n] = x[n-31] ^ x[n-28], first 31 = seed.
    bit px [2][NPX];

    always #5 clk = ~clk;

    stream_pattern_gen #(.TDATA_WIDTH(TW), .PRBS_SEED(SEED)) dut (
        .clk           (clk),
        .areset        (areset),
        .start         (start),
        .stop          (stop),
        .mode          (mode),
        .fixed_word    (fixed_word),
        .num_words     (num_words),
`ifdef STREAM_PATTERN_GEN_ERR_INJECT_EN
        .err_inject    (err_inject),
        .inject_count  (inject_count),
`endif
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TREADY (tready),
        .M_AXIS_TLAST  (tlast),
        .busy          (busy),
        .done          (done),
        .words_sent    (words_sent)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int md, input logic [31:0] fw,
                                             input int k, input int l);
        logic [31:0] w;
        w = '0;
        case (md)
            1: for (int b = 0; b < 32; b++) w[31 - b] = px[l][31 + 32*k + b];
            2: w = fw;
            default: w = 32'(k + l);
        endcase
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete run, checked beat by beat; stop is issued on a forced
    // stall while beat stop_beat is presented (-1: never).
    task automatic run(input int md, input logic [31:0] fw, input int num,
                       input int stop_beat, input int rdy_pct, output int sent);
        int k;
        int cyc;
        bit pend, issued, fin;
        k = 0; cyc = 0; pend = 0; issued = 0; fin = 0;
        start = 1'b1; mode = md[1:0]; fixed_word = fw; num_words = num;
        tick();
        start = 1'b0; mode = 2'($urandom); fixed_word = $urandom; num_words = $urandom;
        while (!fin && cyc < 5000) begin
            check("tvalid", tvalid, 1);
            check("busy", busy, 1);
            check("done_run", done, 0);
            check("words_sent", words_sent, k);
            check("tdata", tdata, {exp_word(md, fw, k, 1), exp_word(md, fw, k, 0)});
            check("tlast", tlast, (num != 0 && k == num - 1));
            if (md == 1) begin
                check("prbs_links_differ", tdata[31:0] != tdata[63:32], 1);
                check("prbs_nonzero", (tdata[31:0] != 0) && (tdata[63:32] != 0), 1);
            end
            tready = ($urandom_range(99) < rdy_pct);
            if (!issued && k == stop_beat) begin
                tready = 1'b0;
                stop   = 1'b1;
                issued = 1;
            end
            start = ($urandom_range(7) == 0);
            tick();
            stop = 1'b0;
            if (tready) begin
                k++;
                if ((num != 0 && k == num) || pend) fin = 1;
            end
            if (issued) pend = 1;
            cyc++;
        end
        start = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: got %0d beats expected end of run", k);
            areset = 1'b1;
            tick();
            areset = 1'b0;
        end else begin
            check("fin_tvalid", tvalid, 0);
            check("fin_done", done, 1);
            check("fin_tlast", tlast, 0);
            check("fin_words", words_sent, k);
            tick();
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
            check("idle_tvalid", tvalid, 0);
            check("idle_words", words_sent, k);
        end
        sent = k;
    endtask

    typedef struct {
        int          md;
        logic [31:0] fw;
        int          num;
        int          stop_beat;
        int          rdy;
        int          exp_sent;
    } vec_t;

    vec_t        tbl [10];
    logic [63:0] lit [4];

    initial begin
        int          s;
        logic [30:0] sd;

        tbl[0] = '{0, 32'h0,         4,  -1, 100, 4};
        tbl[1] = '{0, 32'h0,         25, -1, 50,  25};
        tbl[2] = '{3, 32'h0,         7,  -1, 70,  7};
        tbl[3] = '{2, 32'hA5A51234,  9,  -1, 60,  9};
        tbl[4] = '{0, 32'h0,         0,  12, 60,  13};
        tbl[5] = '{1, 32'h0,         0,  999, 100, 1000};
        tbl[6] = '{0, 32'h0,         1,  -1, 40,  1};
        tbl[7] = '{1, 32'h0,         40, -1, 50,  40};
        tbl[8] = '{2, 32'hFFFF0000,  0,  0,  80,  1};
        tbl[9] = '{0, 32'h0,         5,  4,  100, 5};

        for (int l = 0; l < 2; l++) begin
            sd = SEED ^ 31'(l);
            if (sd == 31'd0) sd = 31'd1;
            for (int j = 0; j < 31; j++) px[l][j] = sd[30 - j];
            for (int n = 31; n < NPX; n++) px[l][n] = px[l][n-31] ^ px[l][n-28];
        end

        areset = 1'b1; start = 1'b0; stop = 1'b0; tready = 1'b0;
        mode = '0; fixed_word = '0; num_words = '0;
`ifdef STREAM_PATTERN_GEN_ERR_INJECT_EN
        err_inject = 1'b0;
`endif
        repeat (3) tick();
        areset = 1'b0;
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_words", words_sent, 0);

        // stop while idle must not leave anything pending
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("idle_stop_busy", busy, 0);

        // Directed counter run, literal beats link1:link0
        lit[0] = 64'h00000001_00000000;
        lit[1] = 64'h00000002_00000001;
        lit[2] = 64'h00000003_00000002;
        lit[3] = 64'h00000004_00000003;
        tready = 1'b1; mode = 2'd0; num_words = 32'd4; start = 1'b1;
        check("dir_pre_tvalid", tvalid, 0);
        tick();
        start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            check("dir_tdata", tdata, lit[b]);
            check("dir_tlast", tlast, (b == 3));
            tick();
        end
        check("dir_done", done, 1);
        check("dir_tvalid", tvalid, 0);
        check("dir_words", words_sent, 4);
        tick();
        check("dir_done_clr", done, 0);

        // Table of runs
        for (int r = 0; r < 10; r++) begin
            run(tbl[r].md, tbl[r].fw, tbl[r].num, tbl[r].stop_beat, tbl[r].rdy, s);
            check("row_sent", s, tbl[r].exp_sent);
        end

        // areset mid-run at beat 10
        tready = 1'b1; mode = 2'd0; num_words = 32'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 30 && words_sent != 32'd10; c++) tick();
        check("ar_reach10", words_sent, 10);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check("ar_tvalid", tvalid, 0);
        check("ar_words", words_sent, 0);
        check("ar_done", done, 0);
        check("ar_busy", busy, 0);
        check("ar_tlast", tlast, 0);
        tick();
        check("ar_done_after", done, 0);
        run(0, 32'h0, 3, -1, 100, s);
        check("ar_restart_sent", s, 3);

`ifdef STREAM_PATTERN_GEN_ERR_INJECT_EN
        begin
            int k, nbad, cyc;
            k = 0; nbad = 0; cyc = 0;
            tready = 1'b1; mode = 2'd0; num_words = 32'd10; start = 1'b1;
            tick();
            start = 1'b0;
            while (k < 10 && cyc < 40) begin
                if (tvalid) begin
                    if (tdata[31:0] !== 32'(k)) begin
                        nbad++;
                        check("inj_bit0_flip", tdata[31:0], 32'(k) ^ 32'd1);
                    end
                    check("inj_link1", tdata[63:32], 32'(k + 1));
                end
                err_inject = (k == 5);
                tick();
                err_inject = 1'b0;
                k++;
                cyc++;
            end
            check("inj_bad_beats", nbad, 1);
            check("inj_count", inject_count, 1);
            tick();
            tick();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
